// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter
// Description : Shares one valid/ready memory port between instruction fetch
//               and data access. Data wins ties; a bounded count of
//               consecutive data grants guarantees fetch forward progress.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
  parameter int XLEN      = 32,
  parameter int DPRIO_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,          // asynchronous, active-low

  input  logic            imem_valid,
  input  logic            imem_instr,
  input  logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_wdata,
  input  logic [3:0]      imem_wstrb,
  output logic            imem_ready,
  output logic [XLEN-1:0] imem_rdata,

  input  logic            dmem_valid,
  input  logic            dmem_instr,
  input  logic [XLEN-1:0] dmem_addr,
  input  logic [XLEN-1:0] dmem_wdata,
  input  logic [3:0]      dmem_wstrb,
  output logic            dmem_ready,
  output logic [XLEN-1:0] dmem_rdata,

  output logic            mem_valid,
  output logic            mem_instr,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata
);

  // Counter must be able to hold DPRIO_MAX itself.
  localparam int c_CNT_W = (DPRIO_MAX < 1) ? 1 : $clog2(DPRIO_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_DPRIO = c_CNT_W'(DPRIO_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_IBUSY = 2'd1,
    S_DBUSY = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [c_CNT_W-1:0]   r_dcount;
  logic [c_CNT_W-1:0]   w_next_dcount;
  logic                 w_grant_i;
  logic                 w_grant_d;
  logic                 w_imem_ready;
  logic                 w_dmem_ready;

  logic                 r_mem_valid;
  logic                 r_mem_instr;
  logic [XLEN-1:0]      r_mem_addr;
  logic [XLEN-1:0]      r_mem_wdata;
  logic [3:0]           r_mem_wstrb;

  // State and starvation counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_dcount <= '0;
    end else begin
      r_state  <= w_next_state;
      r_dcount <= w_next_dcount;
    end
  end

  // Grant decision, starvation counting and completion routing.
  always_comb begin
    w_next_state  = r_state;
    w_next_dcount = r_dcount;
    w_grant_i     = 1'b0;
    w_grant_d     = 1'b0;
    w_imem_ready  = 1'b0;
    w_dmem_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (dmem_valid && (!imem_valid || (r_dcount < c_DPRIO))) begin
          // Data wins; only count grants that actually made fetch wait.
          w_grant_d     = 1'b1;
          w_next_state  = S_DBUSY;
          w_next_dcount = imem_valid ? (r_dcount + c_CNT_W'(1)) : '0;
        end else if (imem_valid) begin
          w_grant_i     = 1'b1;
          w_next_state  = S_IBUSY;
          w_next_dcount = '0;
        end else begin
          w_next_dcount = '0;
        end
      end
      S_IBUSY: begin
        if (mem_ready) begin
          w_imem_ready = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      S_DBUSY: begin
        if (mem_ready) begin
          w_dmem_ready = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Latch the granted request; hold it stable for the whole transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_valid <= 1'b0;
      r_mem_instr <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
    end else begin
      r_mem_valid <= (w_next_state != S_IDLE);
      if (w_grant_d) begin
        r_mem_instr <= dmem_instr;
        r_mem_addr  <= dmem_addr;
        r_mem_wdata <= dmem_wdata;
        r_mem_wstrb <= dmem_wstrb;
      end else if (w_grant_i) begin
        r_mem_instr <= imem_instr;
        r_mem_addr  <= imem_addr;
        r_mem_wdata <= imem_wdata;
        r_mem_wstrb <= imem_wstrb;
      end
    end
  end

  assign mem_valid  = r_mem_valid;
  assign mem_instr  = r_mem_instr;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_wstrb  = r_mem_wstrb;

  // Read data is forced to zero outside the owner's ready pulse.
  assign imem_ready = w_imem_ready;
  assign dmem_ready = w_dmem_ready;
  assign imem_rdata = w_imem_ready ? mem_rdata : '0;
  assign dmem_rdata = w_dmem_ready ? mem_rdata : '0;

endmodule
`default_nettype wire
